// File: rtl/slon5_round_ctrl.sv
// slon5_round_ctrl: iterative MD5 round sequencer, one stage per clock, with chaining add and digest handshake
module slon5_round_ctrl #(
  parameter int STAGE_NUM = 64,
  parameter int WORD_W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic         blk_last_i,
  output logic         digest_valid_o,
  input  logic         digest_ready_i,
  output logic [127:0] digest_o,
  output logic         busy_o,
  output logic [5:0]   stage_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;
  localparam logic [127:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [WORD_W-1:0] K_TAB [STAGE_NUM] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  // Shift amount depends only on the round and the stage position modulo 4
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  logic [1:0]        state_q, state_d;
  logic [5:0]        stage_q, stage_d;
  logic [127:0]      h_q, h_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [511:0]      m_q, m_d;
  logic              last_q, last_d;
  logic [1:0]        rnd;
  logic [3:0]        i4, g;
  logic [4:0]        s;
  logic [WORD_W-1:0] f, m_g, sum, rot;

  // Round function, message index and rotation for the current stage
  always_comb begin
    rnd = stage_q[5:4];
    i4  = stage_q[3:0];
    f   = rnd == 2'd0 ? (b_q & c_q) | (~b_q & d_q) :
          rnd == 2'd1 ? (d_q & b_q) | (~d_q & c_q) :
          rnd == 2'd2 ? b_q ^ c_q ^ d_q :
                        c_q ^ (b_q | ~d_q);
    g   = rnd == 2'd0 ? i4 :
          rnd == 2'd1 ? i4 * 4'd5 + 4'd1 :
          rnd == 2'd2 ? i4 * 4'd3 + 4'd5 :
                        i4 * 4'd7;
    s   = S_TAB[{rnd, stage_q[1:0]}];
    m_g = m_q[{g, 5'd0} +: 32];
    sum = a_q + f + K_TAB[stage_q] + m_g;
    rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
  end

  // Next-state for sequencer, working registers and chaining value
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    h_d     = h_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    m_d     = m_q;
    last_d  = last_q;
    if (state_q == S_IDLE && blk_valid_i) begin
      m_d     = blk_data_i;
      last_d  = blk_last_i;
      {d_d, c_d, b_d, a_d} = h_q;
      stage_d = 6'd0;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      a_d     = d_q;
      d_d     = c_q;
      c_d     = b_q;
      b_d     = b_q + rot;
      stage_d = stage_q + 6'd1;
      state_d = stage_q == 6'd63 ? S_ADD : S_RUN;
    end else if (state_q == S_ADD) begin
      h_d     = {h_q[127:96] + d_q, h_q[95:64] + c_q, h_q[63:32] + b_q, h_q[31:0] + a_q};
      state_d = last_q ? S_OUT : S_IDLE;
    end else if (state_q == S_OUT && digest_ready_i) begin
      h_d     = IV;
      state_d = S_IDLE;
    end
  end

  // State registers with asynchronous reset to the idle, IV-loaded condition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      h_q     <= IV;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      h_q     <= h_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      m_q     <= m_d;
      last_q  <= last_d;
    end
  end

  assign blk_ready_o    = state_q == S_IDLE;
  assign digest_valid_o = state_q == S_OUT;
  assign busy_o         = state_q != S_IDLE;
  assign stage_o        = state_q == S_RUN ? stage_q : 6'd0;
  assign digest_o       = h_q;
endmodule

// File: tb/tb_slon5_round_ctrl.sv
// tb_slon5_round_ctrl: directed-vector bench for the slon5 round sequencer
module tb_slon5_round_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [511:0] blk_data_i = '0;
  logic         blk_last_i = 1'b0;
  logic         digest_valid_o;
  logic         digest_ready_i = 1'b0;
  logic [127:0] digest_o;
  logic         busy_o;
  logic [5:0]   stage_o;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] IV      = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] D_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] D_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
  localparam logic [127:0] D_A64   = {32'h67733f79, 32'h63034a5a, 32'h4971b580, 32'hd4424801};

  logic [511:0] blk_empty, blk_abc, blk_a1, blk_a2;
  logic [127:0] held;

  slon5_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_data_i(blk_data_i), .blk_last_i(blk_last_i), .digest_valid_o(digest_valid_o),
    .digest_ready_i(digest_ready_i), .digest_o(digest_o), .busy_o(busy_o), .stage_o(stage_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer a block from the next negedge; returns just after the accepting edge E0
  task automatic send_block(input logic [511:0] d, input logic l);
    bit ok = 0;
    @(negedge clk);
    blk_data_i = d;
    blk_last_i = l;
    blk_valid_i = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (blk_ready_o) ok = 1;
      else @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 blk_valid_i = 1'b0;
  endtask

  // Starting at the negedge after E0, walk the 64 stages, ADD, and land after E65
  task automatic finish_run(input logic l, input bit sched);
    for (int i = 0; i < 64; i++) begin
      if (sched) check("stage", stage_o, i);
      @(negedge clk);
    end
    check("add_valid", digest_valid_o, 0);
    check("add_busy", busy_o, 1);
    check("add_stage", stage_o, 0);
    @(negedge clk);
    check("e65_valid", digest_valid_o, l);
    check("e65_ready", blk_ready_o, !l);
  endtask

  task automatic run_block(input logic [511:0] d, input logic l, input bit sched);
    send_block(d, l);
    @(negedge clk);
    check("e0_busy", busy_o, 1);
    finish_run(l, sched);
  endtask

  // Called at the negedge after E65 with digest valid; transfer happens at E66
  task automatic take_digest(input string tag, input logic [127:0] exp);
    check(tag, digest_o, exp);
    digest_ready_i = 1'b1;
    @(negedge clk);
    check("xfer_valid", digest_valid_o, 0);
    check("xfer_ready", blk_ready_o, 1);
    digest_ready_i = 1'b0;
  endtask

  initial begin
    blk_empty = '0;
    blk_empty[31:0] = 32'h00000080;
    blk_abc = '0;
    blk_abc[31:0] = 32'h80636261;
    blk_abc[14*32 +: 32] = 32'h00000018;
    blk_a1 = {16{32'h61616161}};
    blk_a2 = '0;
    blk_a2[31:0] = 32'h00000080;
    blk_a2[14*32 +: 32] = 32'h00000200;

    repeat (3) @(negedge clk);
    check("rst_ready", blk_ready_o, 1);
    check("rst_valid", digest_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_stage", stage_o, 0);
    check("rst_digest", digest_o, IV);
    rst_n = 1'b1;

    digest_ready_i = 1'b1;
    run_block(blk_empty, 1'b1, 1'b1);
    take_digest("empty", D_EMPTY);

    run_block(blk_abc, 1'b1, 1'b0);
    take_digest("abc", D_ABC);
    run_block(blk_empty, 1'b1, 1'b0);
    take_digest("empty_reload", D_EMPTY);

    run_block(blk_a1, 1'b0, 1'b0);
    run_block(blk_a2, 1'b1, 1'b0);
    take_digest("a64", D_A64);

    run_block(blk_abc, 1'b1, 1'b0);
    held = digest_o;
    blk_data_i = blk_empty;
    blk_last_i = 1'b1;
    blk_valid_i = 1'b1;
    repeat (10) begin
      check("bp_valid", digest_valid_o, 1);
      check("bp_digest", digest_o, D_ABC);
      check("bp_stable", digest_o, held);
      check("bp_ready", blk_ready_o, 0);
      @(negedge clk);
    end
    digest_ready_i = 1'b1;
    @(negedge clk);
    digest_ready_i = 1'b0;
    check("bp_xfer_valid", digest_valid_o, 0);
    check("bp_xfer_ready", blk_ready_o, 1);
    @(negedge clk);
    blk_valid_i = 1'b0;
    check("bp_accept_busy", busy_o, 1);
    check("bp_accept_ready", blk_ready_o, 0);
    finish_run(1'b1, 1'b0);
    take_digest("bp_empty", D_EMPTY);

    send_block(blk_abc, 1'b1);
    for (int t = 0; t < 100 && stage_o != 6'd30; t++) @(negedge clk);
    check("reach_stage30", stage_o, 30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", blk_ready_o, 1);
    check("mid_rst_valid", digest_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_stage", stage_o, 0);
    check("mid_rst_digest", digest_o, IV);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(blk_abc, 1'b1, 1'b0);
    take_digest("abc_after_rst", D_ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
